// File: rtl/dma_pkg.sv
// Types shared between the DWT line-fetch sequencer and the DMA read engine.
package dma_pkg;

  localparam int DMA_ADDR_W = 32;
  localparam int DMA_LEN_W  = 16;

  typedef enum logic [2:0] {
    LFC_IDLE,
    LFC_INIT,
    LFC_WAIT_PAIR,
    LFC_CALC,
    LFC_ISSUE_EVEN,
    LFC_ISSUE_ODD,
    LFC_DRAIN
  } lfc_state_e;

  typedef struct packed {
    logic [DMA_ADDR_W-1:0] addr;
    logic [DMA_LEN_W-1:0]  len;
    logic                  odd;
    logic                  last;
  } rd_cmd_t;

endpackage

// File: rtl/line_addr_calc.sv
// Registered line-number to byte-address conversion: base + line * stride.
// Product and sum wrap silently at ADDR_W bits.
module line_addr_calc #(
  parameter int ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              en_i,
  input  logic [ADDR_W-1:0] base_i,
  input  logic [ADDR_W-1:0] stride_i,
  input  logic [ADDR_W-1:0] line_i,
  output logic [ADDR_W-1:0] addr_o
);

  logic [ADDR_W-1:0] addr_reg;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      addr_reg <= '0;
    end else if (en_i) begin
      addr_reg <= base_i + line_i * stride_i;
    end
  end

  assign addr_o = addr_reg;

endmodule

// File: rtl/dwt_line_fetch_ctrl.sv
// Frame sequencer: takes even/odd line pairs from LineNumberFormer and issues
// one DMA read per line, bounding in-flight reads and signalling frame end.
module dwt_line_fetch_ctrl
  import dma_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int LEN_W   = 16,
  parameter int MAX_OUT = 4
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [ADDR_W-1:0] stride_i,
  input  logic [ADDR_W-1:0] vsize_i,
  input  logic [LEN_W-1:0]  line_len_i,
  output logic              busy_o,
  output logic              frame_done_o,
  output logic              lnf_new_frame_o,
  output logic [ADDR_W-1:0] lnf_vsize_o,
  input  logic              lnf_valid_i,
  output logic              lnf_ready_o,
  input  logic [ADDR_W-1:0] lnf_even_i,
  input  logic [ADDR_W-1:0] lnf_odd_i,
  input  logic              lnf_last_i,
  output logic              cmd_valid_o,
  input  logic              cmd_ready_i,
  output logic [ADDR_W-1:0] cmd_addr_o,
  output logic [LEN_W-1:0]  cmd_len_o,
  output logic              cmd_odd_o,
  output logic              cmd_last_o,
  input  logic              rd_done_i
);

  localparam int CNT_W = $clog2(MAX_OUT + 1);
  // A pair costs two commands, so leave room for both before accepting it.
  localparam logic [CNT_W-1:0] READY_MAX = CNT_W'(MAX_OUT - 2);

  lfc_state_e state_reg, state_next;

  logic [ADDR_W-1:0]           base_reg;
  logic [ADDR_W-1:0]           stride_reg;
  logic [ADDR_W-1:0]           vsize_reg;
  logic [LEN_W-1:0]            len_reg;
  logic [1:0][ADDR_W-1:0]      line_reg;
  logic [1:0][ADDR_W-1:0]      line_addr;
  logic                        last_reg;
  logic [CNT_W-1:0]            outstanding_reg, outstanding_next;

  logic start_ok;
  logic pair_hs;
  logic cmd_hs;
  logic calc_en;

  assign start_ok = (state_reg == LFC_IDLE) && start_i;
  assign pair_hs  = lnf_valid_i && lnf_ready_o;
  assign cmd_hs   = cmd_valid_o && cmd_ready_i;
  assign calc_en  = (state_reg == LFC_CALC);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_reg       <= LFC_IDLE;
      base_reg        <= '0;
      stride_reg      <= '0;
      vsize_reg       <= '0;
      len_reg         <= '0;
      line_reg        <= '0;
      last_reg        <= 1'b0;
      outstanding_reg <= '0;
    end else begin
      state_reg       <= state_next;
      outstanding_reg <= outstanding_next;
      if (start_ok) begin
        base_reg   <= base_addr_i;
        stride_reg <= stride_i;
        vsize_reg  <= vsize_i;
        len_reg    <= line_len_i;
      end
      if (pair_hs) begin
        line_reg[0] <= lnf_even_i;
        line_reg[1] <= lnf_odd_i;
        last_reg    <= lnf_last_i;
      end
    end
  end

  // Index 0 converts the even line, index 1 the odd line.
  for (genvar gi = 0; gi < 2; gi++) begin : g_calc
    line_addr_calc #(
      .ADDR_W (ADDR_W)
    ) u_line_addr_calc (
      .clk_i    (clk_i),
      .rst_n_i  (rst_n_i),
      .en_i     (calc_en),
      .base_i   (base_reg),
      .stride_i (stride_reg),
      .line_i   (line_reg[gi]),
      .addr_o   (line_addr[gi])
    );
  end

  // A done that coincides with a new command cancels it; a stray done at zero is dropped.
  always_comb begin
    outstanding_next = outstanding_reg;
    if (cmd_hs && !rd_done_i) begin
      outstanding_next = outstanding_reg + 1'b1;
    end else if (!cmd_hs && rd_done_i && (outstanding_reg != '0)) begin
      outstanding_next = outstanding_reg - 1'b1;
    end
  end

  always_comb begin
    state_next      = state_reg;
    lnf_new_frame_o = 1'b0;
    lnf_ready_o     = 1'b0;
    cmd_valid_o     = 1'b0;
    cmd_odd_o       = 1'b0;
    cmd_last_o      = 1'b0;
    frame_done_o    = 1'b0;
    case (state_reg)
      LFC_IDLE: begin
        if (start_i) state_next = LFC_INIT;
      end
      LFC_INIT: begin
        lnf_new_frame_o = 1'b1;
        state_next      = LFC_WAIT_PAIR;
      end
      LFC_WAIT_PAIR: begin
        lnf_ready_o = (outstanding_reg <= READY_MAX);
        if (lnf_valid_i && (outstanding_reg <= READY_MAX)) state_next = LFC_CALC;
      end
      LFC_CALC: begin
        state_next = LFC_ISSUE_EVEN;
      end
      LFC_ISSUE_EVEN: begin
        cmd_valid_o = 1'b1;
        if (cmd_ready_i) state_next = LFC_ISSUE_ODD;
      end
      LFC_ISSUE_ODD: begin
        cmd_valid_o = 1'b1;
        cmd_odd_o   = 1'b1;
        cmd_last_o  = last_reg;
        if (cmd_ready_i) state_next = last_reg ? LFC_DRAIN : LFC_WAIT_PAIR;
      end
      LFC_DRAIN: begin
        if (outstanding_reg == '0) begin
          frame_done_o = 1'b1;
          state_next   = LFC_IDLE;
        end
      end
      default: begin
        state_next = LFC_IDLE;
      end
    endcase
  end

  assign busy_o      = (state_reg != LFC_IDLE);
  assign lnf_vsize_o = vsize_reg;
  assign cmd_addr_o  = (state_reg == LFC_ISSUE_ODD) ? line_addr[1] : line_addr[0];
  assign cmd_len_o   = len_reg;

endmodule

// File: tb/tb_dwt_line_fetch_ctrl.sv
// Self-checking bench for dwt_line_fetch_ctrl: table-driven frames, hand-written
// corner sequences and random frames checked against a line-address model.
module tb_dwt_line_fetch_ctrl;

  localparam int MAX_OUT = 4;
  localparam int FRAME_LIMIT = 3000;

  logic        clk_i;
  logic        rst_n_i;
  logic        start_i;
  logic [31:0] base_addr_i;
  logic [31:0] stride_i;
  logic [31:0] vsize_i;
  logic [15:0] line_len_i;
  logic        busy_o;
  logic        frame_done_o;
  logic        lnf_new_frame_o;
  logic [31:0] lnf_vsize_o;
  logic        lnf_valid_i;
  logic        lnf_ready_o;
  logic [31:0] lnf_even_i;
  logic [31:0] lnf_odd_i;
  logic        lnf_last_i;
  logic        cmd_valid_o;
  logic        cmd_ready_i;
  logic [31:0] cmd_addr_o;
  logic [15:0] cmd_len_o;
  logic        cmd_odd_o;
  logic        cmd_last_o;
  logic        rd_done_i;

  dwt_line_fetch_ctrl #(
    .ADDR_W  (32),
    .LEN_W   (16),
    .MAX_OUT (MAX_OUT)
  ) dut (
    .clk_i           (clk_i),
    .rst_n_i         (rst_n_i),
    .start_i         (start_i),
    .base_addr_i     (base_addr_i),
    .stride_i        (stride_i),
    .vsize_i         (vsize_i),
    .line_len_i      (line_len_i),
    .busy_o          (busy_o),
    .frame_done_o    (frame_done_o),
    .lnf_new_frame_o (lnf_new_frame_o),
    .lnf_vsize_o     (lnf_vsize_o),
    .lnf_valid_i     (lnf_valid_i),
    .lnf_ready_o     (lnf_ready_o),
    .lnf_even_i      (lnf_even_i),
    .lnf_odd_i       (lnf_odd_i),
    .lnf_last_i      (lnf_last_i),
    .cmd_valid_o     (cmd_valid_o),
    .cmd_ready_i     (cmd_ready_i),
    .cmd_addr_o      (cmd_addr_o),
    .cmd_len_o       (cmd_len_o),
    .cmd_odd_o       (cmd_odd_o),
    .cmd_last_o      (cmd_last_o),
    .rd_done_i       (rd_done_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] addr;
    logic [15:0] len;
    logic        odd;
    logic        last;
  } cmd_t;

  // pct == 0 selects "stall five cycles before every command"; pat 1 is a single (2,2) pair.
  typedef struct {
    logic [31:0] base;
    logic [31:0] stride;
    logic [31:0] vsize;
    logic [15:0] len;
    int          pct;
    int          lat;
    int          pat;
    int          exp_ncmd;
    logic [31:0] exp_first;
    logic [31:0] exp_last;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] pe_q[$];
  logic [31:0] po_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    start_i     = 1'b0;
    lnf_valid_i = 1'b0;
    lnf_even_i  = '0;
    lnf_odd_i   = '0;
    lnf_last_i  = 1'b0;
    cmd_ready_i = 1'b0;
    rd_done_i   = 1'b0;
  endtask

  task automatic build_pairs(input logic [31:0] vsize, input int pat);
    pe_q.delete();
    po_q.delete();
    if (pat == 1) begin
      pe_q.push_back(32'd2);
      po_q.push_back(32'd2);
    end else begin
      // Bottom edge is mirrored when the frame has an odd number of lines.
      for (longint l = 0; l <= longint'(vsize); l += 2) begin
        pe_q.push_back(32'(l));
        po_q.push_back((l + 1 <= longint'(vsize)) ? 32'(l + 1) : 32'(l));
      end
    end
  endtask

  task automatic do_start(input logic [31:0] base, stride, vsize, input logic [15:0] len);
    start_i     = 1'b1;
    base_addr_i = base;
    stride_i    = stride;
    vsize_i     = vsize;
    line_len_i  = len;
    @(negedge clk_i);
    start_i = 1'b0;
    chk("new_frame_pulse", lnf_new_frame_o, 1);
    chk("busy_after_start", busy_o, 1);
    chk("lnf_vsize", lnf_vsize_o, vsize);
    chk("ready_low_in_init", lnf_ready_o, 0);
  endtask

  task automatic run_frame(input logic [31:0] base, stride, vsize, input logic [15:0] len,
                           input int pct, input int lat,
                           output int ncmd, output logic [31:0] first_addr, output logic [31:0] last_addr);
    cmd_t exp_q[$];
    cmd_t c;
    int   done_q[$];
    int   model_out = 0;
    int   cyc = 0;
    int   pi = 0;
    int   stall_cnt = 0;
    bit   fin = 0;
    bit   prev_stall = 0;
    bit   hs;
    logic [49:0] saved = '0;
    ncmd = 0;
    first_addr = '0;
    last_addr = '0;
    for (int i = 0; i < pe_q.size(); i++) begin
      c.addr = base + pe_q[i] * stride;
      c.len  = len;
      c.odd  = 1'b0;
      c.last = 1'b0;
      exp_q.push_back(c);
      c.addr = base + po_q[i] * stride;
      c.odd  = 1'b1;
      c.last = (i == pe_q.size() - 1);
      exp_q.push_back(c);
    end
    do_start(base, stride, vsize, len);
    while (!fin) begin
      base_addr_i = $urandom;
      stride_i    = $urandom;
      vsize_i     = $urandom;
      line_len_i  = 16'($urandom);
      chk("outstanding", 64'(dut.outstanding_reg), 64'(model_out));
      chk("busy_in_frame", busy_o, 1);
      if (cyc == 1) chk("new_frame_one_cycle", lnf_new_frame_o, 0);
      if (prev_stall) chk("cmd_stable", {cmd_valid_o, cmd_addr_o, cmd_len_o, cmd_odd_o, cmd_last_o}, {1'b1, saved});
      if (exp_q.size() == 0 && model_out == 0) chk("frame_done_due", frame_done_o, 1);
      if (frame_done_o) begin
        chk("done_cmds_left", 64'(exp_q.size()), 0);
        chk("done_outstanding", 64'(model_out), 0);
        fin = 1;
      end
      rd_done_i = 1'b0;
      if (done_q.size() > 0 && done_q[0] == cyc) begin
        rd_done_i = 1'b1;
        void'(done_q.pop_front());
      end
      if (pct == 0) cmd_ready_i = (stall_cnt >= 5);
      else          cmd_ready_i = ($urandom_range(1, 100) <= pct);
      lnf_valid_i = (pi < pe_q.size()) && ($urandom_range(1, 100) <= 75);
      if (pi < pe_q.size()) begin
        lnf_even_i = pe_q[pi];
        lnf_odd_i  = po_q[pi];
        lnf_last_i = (pi == pe_q.size() - 1);
      end
      if (lnf_valid_i && lnf_ready_o) begin
        chk("pair_gate", (model_out <= MAX_OUT - 2), 1);
        pi++;
      end
      hs = cmd_valid_o && cmd_ready_i;
      if (hs) begin
        if (exp_q.size() == 0) begin
          chk("extra_cmd", cmd_valid_o, 0);
        end else begin
          c = exp_q.pop_front();
          chk("cmd", {cmd_addr_o, cmd_len_o, cmd_odd_o, cmd_last_o}, {c.addr, c.len, c.odd, c.last});
        end
        $display("cmd t=%0t addr=0x%08h len=%0d odd=%0d last=%0d", $time, cmd_addr_o, cmd_len_o, cmd_odd_o, cmd_last_o);
        if (ncmd == 0) first_addr = cmd_addr_o;
        last_addr = cmd_addr_o;
        ncmd++;
        done_q.push_back(cyc + lat);
        stall_cnt = 0;
      end else if (cmd_valid_o) begin
        stall_cnt++;
      end
      prev_stall = cmd_valid_o && !cmd_ready_i;
      saved = {cmd_addr_o, cmd_len_o, cmd_odd_o, cmd_last_o};
      model_out = model_out + (hs ? 1 : 0) - (rd_done_i ? 1 : 0);
      cyc++;
      if (!fin && cyc > FRAME_LIMIT) begin
        n_vec++;
        n_err++;
        $display("FAIL frame_timeout: no frame_done_o after %0d cycles, required within %0d", cyc, FRAME_LIMIT);
        fin = 1;
      end
      @(negedge clk_i);
    end
    clear_inputs();
    chk("busy_after_done", busy_o, 0);
    chk("done_single_pulse", frame_done_o, 0);
  endtask

  // Outstanding-limit gating with withheld completions, then a reset while in ISSUE_ODD.
  task automatic gate_and_reset();
    int  hs_cnt = 0;
    bit  pend;
    bit  found = 0;
    do_start(32'h0, 32'h100, 32'd7, 16'd32);
    cmd_ready_i = 1'b1;
    lnf_valid_i = 1'b1;
    lnf_even_i  = 32'd0;
    lnf_odd_i   = 32'd1;
    lnf_last_i  = 1'b0;
    for (int k = 0; k < 14; k++) begin
      pend = lnf_valid_i && lnf_ready_o;
      @(negedge clk_i);
      if (pend) begin
        hs_cnt++;
        lnf_even_i = 32'(2 * hs_cnt);
        lnf_odd_i  = 32'(2 * hs_cnt + 1);
      end
    end
    chk("gate_pairs_taken", 64'(hs_cnt), 2);
    chk("gate_outstanding_full", 64'(dut.outstanding_reg), 4);
    chk("gate_ready_blocked", lnf_ready_o, 0);
    rd_done_i = 1'b1;
    @(negedge clk_i);
    rd_done_i = 1'b0;
    chk("gate_one_done_still_blocked", lnf_ready_o, 0);
    @(negedge clk_i);
    chk("gate_one_done_still_blocked2", lnf_ready_o, 0);
    rd_done_i = 1'b1;
    @(negedge clk_i);
    rd_done_i = 1'b0;
    chk("gate_two_done_ready", lnf_ready_o, 1);
    @(negedge clk_i);
    lnf_valid_i = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      if (cmd_valid_o && cmd_odd_o) begin
        found = 1;
        cmd_ready_i = 1'b0;
      end else begin
        @(negedge clk_i);
      end
    end
    chk("reach_issue_odd", found, 1);
    chk("issue_odd_addr", cmd_addr_o, 32'h500);
    #2 rst_n_i = 1'b0;
    #1;
    chk("async_reset_ctrl", {busy_o, frame_done_o, lnf_new_frame_o, lnf_ready_o, cmd_valid_o, cmd_odd_o, cmd_last_o}, 0);
    chk("async_reset_data", {cmd_addr_o, cmd_len_o, lnf_vsize_o}, 0);
    clear_inputs();
    repeat (2) @(negedge clk_i);
    chk("reset_no_done", frame_done_o, 0);
    rst_n_i = 1'b1;
    @(negedge clk_i);
  endtask

  vec_t tbl[7];

  initial begin
    int          ncmd;
    logic [31:0] fa, la;
    logic [31:0] rb, rs;
    int          np;
    logic [31:0] e;

    tbl[0] = '{32'h1000,     32'h200,  32'd3, 16'd256,  100, 2, 0, 4,  32'h1000,     32'h1600};
    tbl[1] = '{32'h8000,     32'h40,   32'd1, 16'd64,   0,   3, 0, 2,  32'h8000,     32'h8040};
    tbl[2] = '{32'h2000,     32'h10,   32'd0, 16'd16,   100, 2, 1, 2,  32'h2020,     32'h2020};
    tbl[3] = '{32'h30000,    32'h100,  32'd4, 16'd128,  100, 4, 0, 6,  32'h30000,    32'h30400};
    tbl[4] = '{32'h100,      32'h80,   32'd7, 16'd512,  100, 1, 0, 8,  32'h100,      32'h480};
    tbl[5] = '{32'hFFFFFF00, 32'h100,  32'd3, 16'd32,   100, 3, 0, 4,  32'hFFFFFF00, 32'h200};
    tbl[6] = '{32'h40000000, 32'h1000, 32'd9, 16'd1024, 60,  5, 0, 10, 32'h40000000, 32'h40009000};

    clear_inputs();
    base_addr_i = '0;
    stride_i    = '0;
    vsize_i     = '0;
    line_len_i  = '0;
    rst_n_i     = 1'b1;
    #1 rst_n_i  = 1'b0;
    repeat (3) @(negedge clk_i);
    chk("reset_ctrl", {busy_o, frame_done_o, lnf_new_frame_o, lnf_ready_o, cmd_valid_o, cmd_odd_o, cmd_last_o}, 0);
    chk("reset_data", {cmd_addr_o, cmd_len_o, lnf_vsize_o}, 0);
    chk("reset_outstanding", 64'(dut.outstanding_reg), 0);
    rst_n_i = 1'b1;
    @(negedge clk_i);

    for (int i = 0; i < 7; i++) begin
      build_pairs(tbl[i].vsize, tbl[i].pat);
      run_frame(tbl[i].base, tbl[i].stride, tbl[i].vsize, tbl[i].len, tbl[i].pct, tbl[i].lat, ncmd, fa, la);
      chk("tbl_ncmd", 64'(ncmd), 64'(tbl[i].exp_ncmd));
      chk("tbl_first_addr", fa, tbl[i].exp_first);
      chk("tbl_last_addr", la, tbl[i].exp_last);
    end

    rd_done_i = 1'b1;
    @(negedge clk_i);
    rd_done_i = 1'b0;
    chk("idle_done_saturates", 64'(dut.outstanding_reg), 0);
    chk("idle_done_not_busy", busy_o, 0);

    gate_and_reset();
    build_pairs(tbl[0].vsize, tbl[0].pat);
    run_frame(tbl[0].base, tbl[0].stride, tbl[0].vsize, tbl[0].len, tbl[0].pct, tbl[0].lat, ncmd, fa, la);
    chk("post_reset_ncmd", 64'(ncmd), 64'(tbl[0].exp_ncmd));

    for (int f = 0; f < 12; f++) begin
      rb = $urandom;
      rs = 32'($urandom_range(1, 4096));
      np = $urandom_range(1, 4);
      pe_q.delete();
      po_q.delete();
      for (int p = 0; p < np; p++) begin
        e = 32'($urandom_range(0, 200));
        pe_q.push_back(e);
        po_q.push_back(($urandom_range(0, 3) == 0) ? e : e + 32'd1);
      end
      run_frame(rb, rs, 32'($urandom_range(0, 500)), 16'($urandom_range(1, 4096)),
                $urandom_range(30, 100), $urandom_range(1, 8), ncmd, fa, la);
      chk("rand_ncmd", 64'(ncmd), 64'(2 * np));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
